// File: rtl/fdiv_pkg.sv
// fdiv_pkg: default frequencies and counter-width helper for the fdiv clock divider.
package fdiv_pkg;
  localparam int FDIV_CLK_IN_HZ_DEF = 50_000_000;
  localparam int FDIV_CLK_OUT_HZ_DEF = 1;
  function automatic int fdiv_cnt_w(input int half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction
endpackage

// File: rtl/fdiv_counter.sv
// fdiv_counter: modulo-N up counter with explicit wrap; tc flags cnt == N-1.
module fdiv_counter
  import fdiv_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk_50mHz,
  input  logic rst,
  output logic tc
);
  localparam int W = fdiv_cnt_w(N);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(N - 1);
  always_ff @(posedge clk_50mHz or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/fdiv.sv
// fdiv: 50%-duty clock divider with registered output; optional tick_1Hz strobe under FDIV_TICK_EN.
module fdiv
  import fdiv_pkg::*;
#(
  parameter int CLK_IN_HZ = FDIV_CLK_IN_HZ_DEF,
  parameter int CLK_OUT_HZ = FDIV_CLK_OUT_HZ_DEF
) (
  input  logic clk_50mHz,
  input  logic rst,
`ifdef FDIV_TICK_EN
  output logic tick_1Hz,
`else
`endif
  output logic clk_1Hz
);
  localparam int HALF_PERIOD = (CLK_OUT_HZ > 0) ? CLK_IN_HZ / (2 * CLK_OUT_HZ) : 0;
  if (HALF_PERIOD < 1 || HALF_PERIOD * 2 * CLK_OUT_HZ != CLK_IN_HZ) begin : g_bad_ratio
    $error("fdiv: CLK_IN_HZ/(2*CLK_OUT_HZ) must be an exact integer >= 1");
  end
  logic tc;
  fdiv_counter #(.N(HALF_PERIOD > 0 ? HALF_PERIOD : 1)) u_cnt (
    .clk_50mHz(clk_50mHz),
    .rst(rst),
    .tc(tc)
  );
  always_ff @(posedge clk_50mHz or posedge rst)
    if (rst) clk_1Hz <= 1'b0;
    else if (tc) clk_1Hz <= ~clk_1Hz;
`ifdef FDIV_TICK_EN
  // Fires in the cycle the output goes 0->1
  always_ff @(posedge clk_50mHz or posedge rst)
    if (rst) tick_1Hz <= 1'b0;
    else tick_1Hz <= tc & ~clk_1Hz;
`else
`endif
endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: checks fdiv against an edges-since-release model for three divide ratios.
module tb_fdiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_a, clk_m, clk_d;
  int tests = 0;
  int fails = 0;
  int k = 0;
  always #20 clk = ~clk;
`ifdef FDIV_TICK_EN
  logic tick_a, tick_m, tick_d;
  fdiv #(.CLK_IN_HZ(10), .CLK_OUT_HZ(1)) dut (.clk_50mHz(clk), .rst(rst), .tick_1Hz(tick_a), .clk_1Hz(clk_a));
  fdiv #(.CLK_IN_HZ(2), .CLK_OUT_HZ(1)) dut_min (.clk_50mHz(clk), .rst(rst), .tick_1Hz(tick_m), .clk_1Hz(clk_m));
  fdiv dut_def (.clk_50mHz(clk), .rst(rst), .tick_1Hz(tick_d), .clk_1Hz(clk_d));
`else
  fdiv #(.CLK_IN_HZ(10), .CLK_OUT_HZ(1)) dut (.clk_50mHz(clk), .rst(rst), .clk_1Hz(clk_a));
  fdiv #(.CLK_IN_HZ(2), .CLK_OUT_HZ(1)) dut_min (.clk_50mHz(clk), .rst(rst), .clk_1Hz(clk_m));
  fdiv dut_def (.clk_50mHz(clk), .rst(rst), .clk_1Hz(clk_d));
`endif
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int exp_clk(input int n, input int h);
    return ((n / h) % 2 == 1) ? 1 : 0;
  endfunction
  function automatic int exp_tick(input int n, input int h);
    return (n >= h && n % (2 * h) == h) ? 1 : 0;
  endfunction
  // Model: rising edges since the last reset release
  always @(posedge clk or posedge rst)
    if (rst) k = 0;
    else k = k + 1;
  always @(negedge clk) begin
    check("model_clk_h5", int'(clk_a), exp_clk(k, 5));
    check("model_clk_h1", int'(clk_m), exp_clk(k, 1));
    check("model_clk_def", int'(clk_d), exp_clk(k, 25_000_000));
`ifdef FDIV_TICK_EN
    check("model_tick_h5", int'(tick_a), exp_tick(k, 5));
    check("model_tick_h1", int'(tick_m), exp_tick(k, 1));
    check("model_tick_def", int'(tick_d), exp_tick(k, 25_000_000));
`endif
  end
  initial begin
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_hold_clk", int'(clk_a), 0);
      check("rst_hold_cnt", int'(dut.u_cnt.cnt), 0);
    end
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (e == 1) check("min_first_toggle", int'(clk_m), 1);
      if (e == 2) check("min_second_toggle", int'(clk_m), 0);
      if (e == 4) check("edge4_low", int'(clk_a), 0);
      if (e == 5) check("edge5_rise", int'(clk_a), 1);
      if (e == 9) check("edge9_high", int'(clk_a), 1);
      if (e == 10) check("edge10_fall", int'(clk_a), 0);
      if (e == 15) check("edge15_rise", int'(clk_a), 1);
      if (e == 100) check("edge100_fall", int'(clk_a), 0);
`ifdef FDIV_TICK_EN
      if (e == 5) check("tick_edge5", int'(tick_a), 1);
      if (e == 6) check("tick_edge6", int'(tick_a), 0);
      if (e == 15) check("tick_edge15", int'(tick_a), 1);
`endif
    end
    repeat (7) @(posedge clk);
    #1 check("mid_high_before_rst", int'(clk_a), 1);
    #4 rst = 1'b1;
    #1 check("async_rst_clk", int'(clk_a), 0);
    check("async_rst_cnt", int'(dut.u_cnt.cnt), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 4) check("restart_edge4_low", int'(clk_a), 0);
      if (e == 5) check("restart_edge5_rise", int'(clk_a), 1);
      if (e == 10) check("restart_edge10_fall", int'(clk_a), 0);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
